// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage behind a combinational instruction ROM.
// Owns the PC and registers each issued instruction for the execute stage.
// JMP and NOP delays are resolved here, so execute only sees issued work.
// Optional feature: define FETCH_PERF_EN to add the oIssueCount output.
`ifndef NOP
`define NOP 4'h0
`endif
`ifndef JMP
`define JMP 4'h9
`endif

module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter int          WAIT_WIDTH = 24
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        iStall,
   input  logic [27:0] iInstruction,
   output logic [15:0] oAddress,
   output logic [27:0] oInstruction,
   output logic        oValid,
   output logic [3:0]  oOpcode,
   output logic [7:0]  oDest,
   output logic [7:0]  oSrc1,
   output logic [7:0]  oSrc0,
   output logic [15:0] oImm,
   output logic        oWaiting
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] oIssueCount
`endif
);

   typedef enum logic {S_FETCH, S_WAIT} state_t;

   state_t                state, state_n;
   logic [15:0]           pc, pc_n;
   logic [27:0]           instr, instr_n;
   logic                  valid, valid_n;
   logic [WAIT_WIDTH-1:0] cnt, cnt_n;

   logic [3:0]  in_op;
   logic [23:0] in_delay;

   assign in_op    = iInstruction[27:24];
   assign in_delay = iInstruction[23:0];

   // State and pipeline registers; everything holds when next == current.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= S_FETCH;
         pc    <= RESET_PC;
         instr <= '0;
         valid <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         instr <= instr_n;
         valid <= valid_n;
         cnt   <= cnt_n;
      end
   end

   // Next-state logic: stall freezes every register, otherwise fetch or count down.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      instr_n = instr;
      valid_n = valid;
      cnt_n   = cnt;
      if (!iStall) begin
         case (state)
            S_FETCH: begin
               if (in_op == `JMP) begin
                  // Jump is a bubble; the last issued instruction stays visible.
                  pc_n    = {8'h00, iInstruction[23:16]};
                  valid_n = 1'b0;
               end else begin
                  instr_n = iInstruction;
                  valid_n = 1'b1;
                  pc_n    = pc + 16'd1;
                  if (in_op == `NOP && in_delay != 24'd0) begin
                     cnt_n   = WAIT_WIDTH'(in_delay);
                     state_n = S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // Exactly D edges spent here; leaving on the edge where cnt==1.
               valid_n = 1'b0;
               cnt_n   = cnt - WAIT_WIDTH'(1);
               if (cnt == WAIT_WIDTH'(1))
                  state_n = S_FETCH;
            end
            default: state_n = S_FETCH;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] issue_cnt;

   // Count every edge that loads a real instruction into the output register.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)
         issue_cnt <= '0;
      else if (!iStall && valid_n)
         issue_cnt <= issue_cnt + 32'd1;
   end

   assign oIssueCount = issue_cnt;
`endif

   assign oAddress     = pc;
   assign oInstruction = instr;
   assign oValid       = valid;
   assign oWaiting     = (state == S_WAIT);
   assign oOpcode      = instr[27:24];
   assign oDest        = instr[23:16];
   assign oSrc1        = instr[15:8];
   assign oSrc0        = instr[7:0];
   assign oImm         = instr[15:0];

endmodule
